// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-ported register file: FSM encoding and
// the zero constants used for the sweep, read masking and address-0 rule.
package regfile_mp_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Widest register supported; narrower files take a low slice of ZERO_WORD.
  localparam int MAX_DATA_W = 256;
  localparam logic [MAX_DATA_W-1:0] ZERO_WORD = '0;

  // Register 0 is hard-wired to zero and never written or marked pending.
  localparam int ADDR_ZERO = 0;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: masks disabled/address-0 reads, forwards
// same-cycle write data (port 1 ahead of port 0), and reports the pending bit.
module regfile_rdport
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              run,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] stored,
  input  logic              pend_bit,
  output logic [DATA_W-1:0] rdata,
  output logic              rpend
);

  // Bypass mux; the write enables arriving here are already qualified.
  always_comb begin
    rdata = ZERO_WORD[DATA_W-1:0];
    rpend = 1'b0;
    if (run && re && (raddr != ADDR_W'(ADDR_ZERO))) begin
      // Pending flag reflects stored state only; same-cycle clears are not forwarded.
      rpend = pend_bit;
      if (we1 && (waddr1 == raddr)) begin
        rdata = wdata1;
      end else if (we0 && (waddr0 == raddr)) begin
        rdata = wdata0;
      end else begin
        rdata = stored;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NUM_RD-read register file with a per-entry pending scoreboard.
// After reset or a clear request the storage is zeroed by a one-entry-per-cycle
// sweep; ready stays low until the sweep has covered every entry.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rpend,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr,
  input  logic                     clr_req,
  output logic                     ready
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t              state_reg;
  logic [ADDR_W-1:0]   sweep_idx_reg;
  logic [DATA_W-1:0]   mem_reg [DEPTH];
  logic [DEPTH-1:0]    pend_reg;
  logic [DEPTH-1:0]    pend_next;
  logic                run;
  logic                wr0_ok;
  logic                wr1_ok;
  logic                mark_ok;

  assign run   = (state_reg == ST_RUN);
  assign ready = run;

  // Writes and marks only take effect in RUN, never at a reset edge, and
  // writes to register 0 are dropped before they reach storage or bypass.
  assign wr0_ok  = run && !rst && we0 && (waddr0 != ADDR_W'(ADDR_ZERO));
  assign wr1_ok  = run && !rst && we1 && (waddr1 != ADDR_W'(ADDR_ZERO));
  assign mark_ok = run && !rst && mark_en;

  // Sweep/run state machine; reset restarts the sweep even mid-sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_INIT;
      sweep_idx_reg <= '0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          sweep_idx_reg <= sweep_idx_reg + 1'b1;
          if (sweep_idx_reg == '1) begin
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (clr_req) begin
            state_reg     <= ST_INIT;
            sweep_idx_reg <= '0;
          end
        end
        default: begin
          state_reg     <= ST_INIT;
          sweep_idx_reg <= '0;
        end
      endcase
    end
  end

  // Storage: sweep zeroes one entry per cycle; in RUN port 1 is applied last so it wins.
  always_ff @(posedge clk) begin
    if (state_reg == ST_INIT) begin
      mem_reg[sweep_idx_reg] <= ZERO_WORD[DATA_W-1:0];
    end else begin
      if (wr0_ok) mem_reg[waddr0] <= wdata0;
      if (wr1_ok) mem_reg[waddr1] <= wdata1;
    end
  end

  // Scoreboard next state: writes clear, a mark applied afterwards wins, the
  // sweep clears entries as it zeroes them, and bit 0 never sets.
  always_comb begin
    pend_next = pend_reg;
    if (state_reg == ST_INIT) begin
      pend_next[sweep_idx_reg] = 1'b0;
    end else begin
      if (wr0_ok)  pend_next[waddr0]    = 1'b0;
      if (wr1_ok)  pend_next[waddr1]    = 1'b0;
      if (mark_ok) pend_next[mark_addr] = 1'b1;
    end
    pend_next[ADDR_ZERO] = 1'b0;
  end

  // Scoreboard register; reset clears every pending bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = raddr[gi*ADDR_W +: ADDR_W];

      regfile_rdport #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
      ) u_rdport (
        .run     (run),
        .re      (re[gi]),
        .raddr   (ra),
        .we0     (wr0_ok),
        .waddr0  (waddr0),
        .wdata0  (wdata0),
        .we1     (wr1_ok),
        .waddr1  (waddr1),
        .wdata1  (wdata1),
        .stored  (mem_reg[ra]),
        .pend_bit(pend_reg[ra]),
        .rdata   (rdata[gi*DATA_W +: DATA_W]),
        .rpend   (rpend[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: the driver sets inputs just after each rising
// edge and queues the expected read results; a monitor on the falling edge
// pops and compares them against the DUT outputs.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             we0, we1;
  logic [AW-1:0]    waddr0, waddr1;
  logic [DW-1:0]    wdata0, wdata1;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rpend;
  logic             mark_en;
  logic [AW-1:0]    mark_addr;
  logic             clr_req;
  logic             ready;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .we0      (we0),
    .we1      (we1),
    .waddr0   (waddr0),
    .waddr1   (waddr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .re       (re),
    .raddr    (raddr),
    .rdata    (rdata),
    .rpend    (rpend),
    .mark_en  (mark_en),
    .mark_addr(mark_addr),
    .clr_req  (clr_req),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [DW-1:0] data;
    logic        pend;
    logic        rdy;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   tag_cnt = 0;

  task automatic expect_rd(input int port, input logic [DW-1:0] data,
                           input logic pend, input logic rdy);
    exp_t e;
    e.port = port;
    e.data = data;
    e.pend = pend;
    e.rdy  = rdy;
    e.tag  = tag_cnt;
    tag_cnt++;
    exp_q.push_back(e);
  endtask

  task automatic rd(input int port, input logic [AW-1:0] a);
    re[port] = 1'b1;
    raddr[port*AW +: AW] = a;
  endtask

  // Advance one cycle and return all inputs to idle (rst is held as is).
  task automatic tick();
    @(posedge clk);
    #1;
    we0 = 1'b0; we1 = 1'b0;
    waddr0 = '0; waddr1 = '0;
    wdata0 = '0; wdata1 = '0;
    re = '0; raddr = '0;
    mark_en = 1'b0; mark_addr = '0;
    clr_req = 1'b0;
  endtask

  // Monitor: compare every expectation queued for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      $display("chk %0d port %0d rdata=%h rpend=%b ready=%b", mon_e.tag, mon_e.port,
               rdata[mon_e.port*DW +: DW], rpend[mon_e.port], ready);
      total++;
      if (rdata[mon_e.port*DW +: DW] !== mon_e.data) begin
        bad++;
        $display("FAIL rdata chk %0d port %0d: got %h want %h", mon_e.tag, mon_e.port,
                 rdata[mon_e.port*DW +: DW], mon_e.data);
      end
      total++;
      if (rpend[mon_e.port] !== mon_e.pend) begin
        bad++;
        $display("FAIL rpend chk %0d port %0d: got %b want %b", mon_e.tag, mon_e.port,
                 rpend[mon_e.port], mon_e.pend);
      end
      total++;
      if (ready !== mon_e.rdy) begin
        bad++;
        $display("FAIL ready chk %0d: got %b want %b", mon_e.tag, ready, mon_e.rdy);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    we0 = 1'b0; we1 = 1'b0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    re = '0; raddr = '0; mark_en = 1'b0; mark_addr = '0; clr_req = 1'b0;

    // Reset state: INIT, reads masked to zero
    tick();
    tick();
    rd(0, 5'd1);
    expect_rd(0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    rd(1, 5'd31);
    expect_rd(1, 32'h0, 1'b0, 1'b0);

    // Sweep: ready rises after exactly 32 edges
    for (int k = 1; k <= 32; k++) begin
      tick();
      rd(0, AW'((k % 31) + 1));
      expect_rd(0, 32'h0, 1'b0, (k == 32));
    end

    // All registers read zero after the sweep
    for (int r = 1; r <= 31; r++) begin
      tick();
      rd(0, AW'(r));
      rd(1, AW'(32 - r));
      expect_rd(0, 32'h0, 1'b0, 1'b1);
      expect_rd(1, 32'h0, 1'b0, 1'b1);
    end

    // Same-cycle bypass then stored read of r5
    tick();
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    rd(0, 5'd5);
    expect_rd(0, 32'hDEADBEEF, 1'b0, 1'b1);
    tick();
    rd(0, 5'd5);
    expect_rd(0, 32'hDEADBEEF, 1'b0, 1'b1);

    // Both writers on r7: port 1 wins
    tick();
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1111;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2222;
    rd(1, 5'd7);
    rd(0, 5'd5);
    expect_rd(1, 32'h2222, 1'b0, 1'b1);
    expect_rd(0, 32'hDEADBEEF, 1'b0, 1'b1);
    tick();
    rd(0, 5'd7);
    expect_rd(0, 32'h2222, 1'b0, 1'b1);

    // Independent writes on both ports
    tick();
    we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'h0000_0008;
    we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h0000_0006;
    rd(0, 5'd8);
    rd(1, 5'd6);
    expect_rd(0, 32'h8, 1'b0, 1'b1);
    expect_rd(1, 32'h6, 1'b0, 1'b1);
    tick();
    rd(0, 5'd8);
    rd(1, 5'd6);
    expect_rd(0, 32'h8, 1'b0, 1'b1);
    expect_rd(1, 32'h6, 1'b0, 1'b1);

    // r0 is hard zero; mark on r0 stays clear; re=0 masks data
    tick();
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h55;
    mark_en = 1'b1; mark_addr = 5'd0;
    rd(0, 5'd0);
    expect_rd(0, 32'h0, 1'b0, 1'b1);
    tick();
    rd(0, 5'd0);
    raddr[AW +: AW] = 5'd5;
    expect_rd(0, 32'h0, 1'b0, 1'b1);
    expect_rd(1, 32'h0, 1'b0, 1'b1);

    // Scoreboard on r9: mark, write+mark, write alone
    tick();
    mark_en = 1'b1; mark_addr = 5'd9;
    rd(0, 5'd9);
    expect_rd(0, 32'h0, 1'b0, 1'b1);
    tick();
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99;
    mark_en = 1'b1; mark_addr = 5'd9;
    rd(0, 5'd9);
    expect_rd(0, 32'h99, 1'b1, 1'b1);
    tick();
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h77;
    rd(0, 5'd9);
    expect_rd(0, 32'h77, 1'b1, 1'b1);
    tick();
    rd(0, 5'd9);
    expect_rd(0, 32'h77, 1'b0, 1'b1);

    // Clear request, then reset at sweep cycle 10
    tick();
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5;
    rd(0, 5'd3);
    expect_rd(0, 32'hA5, 1'b0, 1'b1);
    tick();
    clr_req = 1'b1;
    rd(0, 5'd3);
    expect_rd(0, 32'hA5, 1'b0, 1'b1);
    for (int s = 1; s <= 10; s++) begin
      tick();
      we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'hBB;
      mark_en = 1'b1; mark_addr = 5'd3;
      rd(0, 5'd3);
      rd(1, 5'd4);
      expect_rd(0, 32'h0, 1'b0, 1'b0);
      expect_rd(1, 32'h0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    clr_req = 1'b1;
    tick();
    rst = 1'b0;
    rd(0, 5'd3);
    expect_rd(0, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 5) clr_req = 1'b1;
      rd(0, 5'd3);
      expect_rd(0, 32'h0, 1'b0, (k == 32));
    end
    tick();
    rd(0, 5'd3);
    rd(1, 5'd7);
    expect_rd(0, 32'h0, 1'b0, 1'b1);
    expect_rd(1, 32'h0, 1'b0, 1'b1);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
